// File: rtl/zpower_pkg.sv
// Shared types and defaults for the rail power sequencer.
package zpower_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RAMP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_DOWN   = 3'd4,
        ST_FAULT  = 3'd5
    } zpower_state_e;

    // Default cycle counts, also reported through the debug/status register map.
    localparam int unsigned NUM_RAILS_DEF    = 4;
    localparam int unsigned DEBOUNCE_CYC_DEF = 16;
    localparam int unsigned TIMEOUT_CYC_DEF  = 100000;
    localparam int unsigned SETTLE_CYC_DEF   = 1000;

    function automatic int unsigned zp_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/zpower_pg_debounce.sv
// One rail's power-good path: 2-FF synchroniser followed by a stability filter.
module zpower_pg_debounce
    import zpower_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic iClk,
    input  logic iRst_N,
    input  logic iPg,
    output logic oPgf
);

    localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic            sync1_q, sync2_q;
    logic            pgf_q, pgf_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Counter only runs while the synced value disagrees with the filtered one;
    // a return to agreement is the only possible "change" for one bit.
    always_comb begin
        pgf_d    = pgf_q;
        db_cnt_d = '0;
        if (sync2_q != pgf_q) begin
            if (db_cnt_q >= DB_LAST) begin
                pgf_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            pgf_q    <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= iPg;
            sync2_q  <= sync1_q;
            pgf_q    <= pgf_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign oPgf = pgf_q;

endmodule

// File: rtl/zpower_sequencer.sv
// Rail enable sequencer: ramps rails in order against filtered power-good,
// holds them, and drops them in reverse on stop or all at once on fault.
//
//  state  | meaning
//  OFF    | all rails off, waiting for iStart
//  RAMP   | enabling rail idx, waiting for its PG (timeout-checked)
//  SETTLE | all PGs seen, waiting SETTLE_CYC before reporting ok
//  ON     | all rails up, oPwrOk asserted, watching for PG loss
//  DOWN   | turning rails off highest-first, SETTLE_CYC apart
//  FAULT  | all rails off, sticky fault until iStart drops
module zpower_sequencer
    import zpower_pkg::*;
#(
    parameter int unsigned NUM_RAILS    = NUM_RAILS_DEF,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
    parameter int unsigned SETTLE_CYC   = SETTLE_CYC_DEF,
    localparam int unsigned IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
    input  logic                 iClk,
    input  logic                 iRst_N,
    input  logic                 iStart,
    input  logic [NUM_RAILS-1:0] iPG,
    output logic [NUM_RAILS-1:0] oEn,
    output logic                 oPwrOk,
    output logic                 oFault,
    output logic [IDX_W-1:0]     oFaultRail,
    output logic [2:0]           oState
);

    localparam int unsigned CNT_W = $clog2(zp_max(TIMEOUT_CYC, SETTLE_CYC));
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_RAILS - 1);

    zpower_state_e        state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_sat;
    logic [NUM_RAILS-1:0] en_q, en_d;
    logic                 pwr_ok_q, pwr_ok_d;
    logic                 fault_q, fault_d;
    logic [IDX_W-1:0]     fault_rail_q, fault_rail_d;

    logic [NUM_RAILS-1:0] pgf;
    logic [NUM_RAILS-1:0] below_idx;
    logic [NUM_RAILS-1:0] ramp_drop, all_drop;

    for (genvar g = 0; g < NUM_RAILS; g++) begin : g_pg
        zpower_pg_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_pg_debounce (
            .iClk  (iClk),
            .iRst_N(iRst_N),
            .iPg   (iPG[g]),
            .oPgf  (pgf[g])
        );
    end

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_RAILS-1:0] m);
        lowest_idx = '0;
        for (int k = NUM_RAILS - 1; k >= 0; k--) begin
            if (m[k]) lowest_idx = IDX_W'(k);
        end
    endfunction

    always_comb begin
        below_idx = '0;
        for (int j = 0; j < NUM_RAILS; j++) begin
            below_idx[j] = (IDX_W'(j) < idx_q);
        end
    end

    // While ramping only rails whose PG was already seen may collapse.
    assign ramp_drop = ~pgf & below_idx;
    assign all_drop  = ~pgf;
    assign cnt_sat   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        en_d         = en_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;

        case (state_q)
            ST_OFF: begin
                en_d = '0;
                if (iStart) begin
                    state_d = ST_RAMP;
                    idx_d   = '0;
                    cnt_d   = '0;
                    en_d    = NUM_RAILS'(1);
                end
            end
            ST_RAMP: begin
                cnt_d = cnt_sat;
                if (|ramp_drop) begin
                    state_d      = ST_FAULT;
                    en_d         = '0;
                    cnt_d        = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = lowest_idx(ramp_drop);
                end else if (!pgf[idx_q] && (cnt_q >= TO_LAST)) begin
                    state_d      = ST_FAULT;
                    en_d         = '0;
                    cnt_d        = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = idx_q;
                end else if (!iStart) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                    en_d    = en_q >> 1;
                end else if (pgf[idx_q]) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_SETTLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        en_d  = (en_q << 1) | NUM_RAILS'(1);
                    end
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_sat;
                if (|all_drop) begin
                    state_d      = ST_FAULT;
                    en_d         = '0;
                    cnt_d        = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = lowest_idx(all_drop);
                end else if (!iStart) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                    en_d    = en_q >> 1;
                end else if (cnt_q >= SETTLE_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
                if (|all_drop) begin
                    state_d      = ST_FAULT;
                    en_d         = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = lowest_idx(all_drop);
                end else if (!iStart) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                    en_d    = en_q >> 1;
                end
            end
            ST_DOWN: begin
                // Enables are a thermometer code, so a right shift drops the top rail.
                if (en_q == '0) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q >= SETTLE_LAST) begin
                    en_d  = en_q >> 1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            ST_FAULT: begin
                en_d = '0;
                if (!iStart) begin
                    state_d      = ST_OFF;
                    fault_d      = 1'b0;
                    fault_rail_d = '0;
                end
            end
            default: begin
                state_d = ST_OFF;
                en_d    = '0;
                cnt_d   = '0;
            end
        endcase

        pwr_ok_d = (state_q == ST_ON) && (state_d == ST_ON);
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            state_q      <= ST_OFF;
            idx_q        <= '0;
            cnt_q        <= '0;
            en_q         <= '0;
            pwr_ok_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            en_q         <= en_d;
            pwr_ok_q     <= pwr_ok_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
        end
    end

    assign oEn        = en_q;
    assign oPwrOk     = pwr_ok_q;
    assign oFault     = fault_q;
    assign oFaultRail = fault_rail_q;
    assign oState     = state_q;

endmodule

// File: tb/tb_zpower_sequencer.sv
// Directed bench for zpower_sequencer with 3 rails, 4-cycle debounce,
// 50-cycle timeout and 10-cycle settle; expected values are hand-computed edge counts.
module tb_zpower_sequencer;

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_RAMP   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_ON     = 3'd3;
    localparam logic [2:0] S_DOWN   = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic       iClk;
    logic       iRst_N;
    logic       iStart;
    logic [2:0] iPG;
    logic [2:0] oEn;
    logic       oPwrOk;
    logic       oFault;
    logic [1:0] oFaultRail;
    logic [2:0] oState;

    int checks = 0;
    int errors = 0;

    zpower_sequencer #(
        .NUM_RAILS   (3),
        .DEBOUNCE_CYC(4),
        .TIMEOUT_CYC (50),
        .SETTLE_CYC  (10)
    ) dut (
        .iClk      (iClk),
        .iRst_N    (iRst_N),
        .iStart    (iStart),
        .iPG       (iPG),
        .oEn       (oEn),
        .oPwrOk    (oPwrOk),
        .oFault    (oFault),
        .oFaultRail(oFaultRail),
        .oState    (oState)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iRst_N = 1'b0;
        iStart = 1'b0;
        iPG    = 3'b000;
        #1;
        checks++; if (oEn !== 3'b000) begin errors++; $display("FAIL reset_en got %b exp 000", oEn); end
        checks++; if (oState !== S_OFF) begin errors++; $display("FAIL reset_state got %0d exp %0d", oState, S_OFF); end
        checks++; if (oPwrOk !== 1'b0 || oFault !== 1'b0 || oFaultRail !== 2'd0) begin
            errors++; $display("FAIL reset_flags got ok=%b fault=%b rail=%0d exp 0 0 0", oPwrOk, oFault, oFaultRail);
        end
        tick(2);
        iRst_N = 1'b1;
        tick(2);
        checks++; if (oState !== S_OFF || oEn !== 3'b000) begin
            errors++; $display("FAIL idle_off got state=%0d en=%b exp 0 000", oState, oEn);
        end
    endtask

    // From OFF with all filtered PGs low; ends at the first cycle of oPwrOk=1.
    task automatic test_normal_ramp();
        iStart = 1'b1;
        tick(1);
        checks++; if (oEn !== 3'b001 || oState !== S_RAMP) begin
            errors++; $display("FAIL ramp_start got en=%b state=%0d exp 001 %0d", oEn, oState, S_RAMP);
        end
        tick(5);  iPG[0] = 1'b1;
        tick(6);
        checks++; if (oEn !== 3'b001) begin errors++; $display("FAIL ramp_en0_hold got %b exp 001", oEn); end
        tick(1);
        checks++; if (oEn !== 3'b011) begin errors++; $display("FAIL ramp_en1 got %b exp 011", oEn); end
        tick(5);  iPG[1] = 1'b1;
        tick(7);
        checks++; if (oEn !== 3'b111) begin errors++; $display("FAIL ramp_en2 got %b exp 111", oEn); end
        tick(5);  iPG[2] = 1'b1;
        tick(7);
        checks++; if (oState !== S_SETTLE) begin errors++; $display("FAIL ramp_settle got %0d exp %0d", oState, S_SETTLE); end
        tick(10);
        checks++; if (oState !== S_ON || oPwrOk !== 1'b0) begin
            errors++; $display("FAIL ramp_on_entry got state=%0d ok=%b exp %0d 0", oState, oPwrOk, S_ON);
        end
        tick(1);
        checks++; if (oPwrOk !== 1'b1 || oFault !== 1'b0 || oEn !== 3'b111) begin
            errors++; $display("FAIL ramp_pwrok got ok=%b fault=%b en=%b exp 1 0 111", oPwrOk, oFault, oEn);
        end
    endtask

    task automatic test_brownout();
        iPG[2] = 1'b0;
        tick(3);
        iPG[2] = 1'b1;
        tick(10);
        checks++; if (oState !== S_ON || oPwrOk !== 1'b1 || oFault !== 1'b0) begin
            errors++; $display("FAIL glitch_ignored got state=%0d ok=%b fault=%b exp %0d 1 0", oState, oPwrOk, oFault, S_ON);
        end
        iPG[2] = 1'b0;
        tick(6);
        iPG[2] = 1'b1;
        checks++; if (oState !== S_ON) begin errors++; $display("FAIL brown_pre got %0d exp %0d", oState, S_ON); end
        tick(1);
        checks++; if (oState !== S_FAULT || oFaultRail !== 2'd2 || oFault !== 1'b1) begin
            errors++; $display("FAIL brown_fault got state=%0d rail=%0d fault=%b exp %0d 2 1", oState, oFaultRail, oFault, S_FAULT);
        end
        checks++; if (oEn !== 3'b000 || oPwrOk !== 1'b0) begin
            errors++; $display("FAIL brown_outputs got en=%b ok=%b exp 000 0", oEn, oPwrOk);
        end
    endtask

    // Ends one cycle into a fresh ramp (RAMP, rail 0 enabled).
    task automatic test_fault_clear();
        iPG = 3'b000;
        tick(100);
        checks++; if (oState !== S_FAULT || oFault !== 1'b1 || oFaultRail !== 2'd2 || oEn !== 3'b000) begin
            errors++; $display("FAIL fault_hold got state=%0d fault=%b rail=%0d en=%b exp %0d 1 2 000", oState, oFault, oFaultRail, oEn, S_FAULT);
        end
        iStart = 1'b0;
        tick(1);
        checks++; if (oState !== S_OFF || oFault !== 1'b0 || oFaultRail !== 2'd0) begin
            errors++; $display("FAIL fault_clear got state=%0d fault=%b rail=%0d exp 0 0 0", oState, oFault, oFaultRail);
        end
        iStart = 1'b1;
        tick(1);
        checks++; if (oState !== S_RAMP || oEn !== 3'b001) begin
            errors++; $display("FAIL fresh_ramp got state=%0d en=%b exp %0d 001", oState, oEn, S_RAMP);
        end
    endtask

    // Continues the fresh ramp; PG[1] never comes up.
    task automatic test_timeout();
        tick(5);  iPG[0] = 1'b1;
        tick(7);
        checks++; if (oEn !== 3'b011) begin errors++; $display("FAIL to_en1 got %b exp 011", oEn); end
        tick(49);
        checks++; if (oState !== S_RAMP || oEn !== 3'b011) begin
            errors++; $display("FAIL to_pre got state=%0d en=%b exp %0d 011", oState, oEn, S_RAMP);
        end
        tick(1);
        checks++; if (oState !== S_FAULT || oFaultRail !== 2'd1 || oFault !== 1'b1) begin
            errors++; $display("FAIL to_fault got state=%0d rail=%0d fault=%b exp %0d 1 1", oState, oFaultRail, oFault, S_FAULT);
        end
        checks++; if (oEn !== 3'b000 || oPwrOk !== 1'b0) begin
            errors++; $display("FAIL to_outputs got en=%b ok=%b exp 000 0", oEn, oPwrOk);
        end
        iStart = 1'b0;
        iPG    = 3'b000;
        tick(1);
        checks++; if (oState !== S_OFF || oFault !== 1'b0) begin
            errors++; $display("FAIL to_clear got state=%0d fault=%b exp 0 0", oState, oFault);
        end
        tick(10);
    endtask

    // From ON; iStart returns high mid-DOWN and must wait for OFF.
    task automatic test_power_down();
        iStart = 1'b0;
        tick(1);
        iPG[2] = 1'b0;
        checks++; if (oEn !== 3'b011 || oState !== S_DOWN || oPwrOk !== 1'b0) begin
            errors++; $display("FAIL down_first got en=%b state=%0d ok=%b exp 011 %0d 0", oEn, oState, oPwrOk, S_DOWN);
        end
        tick(4);
        iStart = 1'b1;
        tick(5);
        checks++; if (oEn !== 3'b011) begin errors++; $display("FAIL down_hold got %b exp 011", oEn); end
        tick(1);
        iPG[1] = 1'b0;
        checks++; if (oEn !== 3'b001 || oState !== S_DOWN) begin
            errors++; $display("FAIL down_second got en=%b state=%0d exp 001 %0d", oEn, oState, S_DOWN);
        end
        tick(10);
        iPG[0] = 1'b0;
        checks++; if (oEn !== 3'b000 || oState !== S_DOWN) begin
            errors++; $display("FAIL down_last got en=%b state=%0d exp 000 %0d", oEn, oState, S_DOWN);
        end
        tick(1);
        checks++; if (oState !== S_OFF || oFault !== 1'b0) begin
            errors++; $display("FAIL down_off got state=%0d fault=%b exp 0 0", oState, oFault);
        end
        tick(1);
        checks++; if (oState !== S_RAMP || oEn !== 3'b001) begin
            errors++; $display("FAIL down_restart got state=%0d en=%b exp %0d 001", oState, oEn, S_RAMP);
        end
    endtask

    // Reset lands between clock edges during RAMP.
    task automatic test_async_reset();
        #2;
        iStart = 1'b0;
        iRst_N = 1'b0;
        #1;
        checks++; if (oEn !== 3'b000 || oState !== S_OFF) begin
            errors++; $display("FAIL arst_immediate got en=%b state=%0d exp 000 0", oEn, oState);
        end
        checks++; if (oPwrOk !== 1'b0 || oFault !== 1'b0 || oFaultRail !== 2'd0) begin
            errors++; $display("FAIL arst_flags got ok=%b fault=%b rail=%0d exp 0 0 0", oPwrOk, oFault, oFaultRail);
        end
        tick(1);
        iRst_N = 1'b1;
        tick(2);
        checks++; if (oState !== S_OFF || oEn !== 3'b000) begin
            errors++; $display("FAIL arst_release got state=%0d en=%b exp 0 000", oState, oEn);
        end
    endtask

    initial begin
        test_reset();
        test_normal_ramp();
        test_brownout();
        test_fault_clear();
        test_timeout();
        test_normal_ramp();
        test_power_down();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
